// File: rtl/mat_vec_res_add.sv
// Drains mat_vec_mul results, adds them bytewise in GF(2^8) to an addend
// vector and writes the sums to an output memory: y = s_A + H*s_B.
module mat_vec_res_add #(
  parameter int VEC_SIZE_BYTES = 8,
  parameter int N_GF           = 2,
  parameter int PROC_SIZE      = N_GF*8,
  parameter int N_WORDS        = (VEC_SIZE_BYTES+N_GF-1)/N_GF,
  parameter int ADDR_W         = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  output logic                 o_res_en,
  output logic [ADDR_W-1:0]    o_res_addr,
  input  logic [PROC_SIZE-1:0] i_res,
  output logic [ADDR_W-1:0]    o_add_addr,
  input  logic [PROC_SIZE-1:0] i_add,
  output logic                 o_out_wr_en,
  output logic [ADDR_W-1:0]    o_out_addr,
  output logic [PROC_SIZE-1:0] o_out_data,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_WORDS-1);
  // bytes of the last word that belong to the vector
  localparam int TAIL_BYTES = VEC_SIZE_BYTES - (N_WORDS-1)*N_GF;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                drain_q, drain_d;

  logic                rd_vld_q, rd_vld_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;

  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [PROC_SIZE-1:0] wr_data_q, wr_data_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      drain_q   <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      drain_q   <= drain_d;
      rd_vld_q  <= rd_vld_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    unique case (state_q)
      IDLE: begin
        drain_d = 1'b0;
        if (i_start) begin
          state_d = READ;
          cnt_d   = '0;
        end
      end
      READ: begin
        if (cnt_q == LAST) begin
          state_d = DRAIN;
          cnt_d   = '0;
          drain_d = 1'b0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (drain_q) begin
          state_d = DONE;
          drain_d = 1'b0;
        end else begin
          drain_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_res_en   = (state_q == READ);
  assign o_res_addr = o_res_en ? cnt_q : '0;
  assign o_add_addr = o_res_addr;
  assign o_busy     = (state_q != IDLE);
  assign o_done     = (state_q == DONE);

  assign rd_vld_d  = o_res_en;
  assign rd_addr_d = o_res_addr;

  // GF(2^8) addition is a plain XOR; padding bytes of the tail word stay zero
  always_comb begin
    wr_data_d = '0;
    if (rd_vld_q) begin
      for (int i = 0; i < N_GF; i++) begin
        if (rd_addr_q != LAST || i < TAIL_BYTES) begin
          wr_data_d[8*i +: 8] = i_res[8*i +: 8] ^ i_add[8*i +: 8];
        end
      end
    end
  end

  assign wr_en_d   = rd_vld_q;
  assign wr_addr_d = rd_vld_q ? rd_addr_q : '0;

  assign o_out_wr_en = wr_en_q;
  assign o_out_addr  = wr_addr_q;
  assign o_out_data  = wr_data_q;

endmodule

// File: tb/tb_mat_vec_res_add.sv
// Bench for mat_vec_res_add: three configurations driven from one clock,
// logged write/read/done events checked against an arithmetic vector model.
module tb_mat_vec_res_add;

  typedef struct {
    int          c;
    int          a;
    logic [31:0] d;
  } ev_t;
  typedef ev_t evq_t[$];
  typedef int  intq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ncmp = 0;
  int nerr = 0;

  logic [31:0] rmem[3][4];
  logic [31:0] amem[3][4];
  logic [2:0]  start;

  // instance 0: VEC=8, N_GF=2
  logic        res_en_a, wr_a, busy_a, done_a;
  logic [1:0]  res_addr_a, add_addr_a, out_addr_a;
  logic [15:0] ires_a, iadd_a, out_data_a;
  // instance 1: VEC=7, N_GF=2
  logic        res_en_b, wr_b, busy_b, done_b;
  logic [1:0]  res_addr_b, add_addr_b, out_addr_b;
  logic [15:0] ires_b, iadd_b, out_data_b;
  // instance 2: VEC=4, N_GF=4
  logic        res_en_c, wr_c, busy_c, done_c;
  logic [0:0]  res_addr_c, add_addr_c, out_addr_c;
  logic [31:0] ires_c, iadd_c, out_data_c;

  mat_vec_res_add #(.VEC_SIZE_BYTES(8), .N_GF(2)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(start[0]),
    .o_res_en(res_en_a), .o_res_addr(res_addr_a), .i_res(ires_a),
    .o_add_addr(add_addr_a), .i_add(iadd_a),
    .o_out_wr_en(wr_a), .o_out_addr(out_addr_a), .o_out_data(out_data_a),
    .o_busy(busy_a), .o_done(done_a)
  );

  mat_vec_res_add #(.VEC_SIZE_BYTES(7), .N_GF(2)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(start[1]),
    .o_res_en(res_en_b), .o_res_addr(res_addr_b), .i_res(ires_b),
    .o_add_addr(add_addr_b), .i_add(iadd_b),
    .o_out_wr_en(wr_b), .o_out_addr(out_addr_b), .o_out_data(out_data_b),
    .o_busy(busy_b), .o_done(done_b)
  );

  mat_vec_res_add #(.VEC_SIZE_BYTES(4), .N_GF(4)) dut_c (
    .i_clk(clk), .i_rst(rst), .i_start(start[2]),
    .o_res_en(res_en_c), .o_res_addr(res_addr_c), .i_res(ires_c),
    .o_add_addr(add_addr_c), .i_add(iadd_c),
    .o_out_wr_en(wr_c), .o_out_addr(out_addr_c), .o_out_data(out_data_c),
    .o_busy(busy_c), .o_done(done_c)
  );

  // synchronous-read memories, one cycle of latency
  always @(posedge clk) begin
    ires_a <= rmem[0][res_addr_a][15:0];
    iadd_a <= amem[0][add_addr_a][15:0];
    ires_b <= rmem[1][res_addr_b][15:0];
    iadd_b <= amem[1][add_addr_b][15:0];
    ires_c <= rmem[2][res_addr_c];
    iadd_c <= amem[2][add_addr_c];
  end

  evq_t  wq[3];
  evq_t  rq[3];
  intq_t dq[3];
  int    bad[3];

  always @(negedge clk) begin
    if (wr_a) wq[0].push_back('{cyc, int'(out_addr_a), 32'(out_data_a)});
    else if (out_addr_a != 0 || out_data_a != 0) bad[0]++;
    if (res_en_a) rq[0].push_back('{cyc, int'(res_addr_a), 32'd0});
    else if (res_addr_a != 0) bad[0]++;
    if (add_addr_a != res_addr_a) bad[0]++;
    if (done_a) dq[0].push_back(cyc);
  end

  always @(negedge clk) begin
    if (wr_b) wq[1].push_back('{cyc, int'(out_addr_b), 32'(out_data_b)});
    else if (out_addr_b != 0 || out_data_b != 0) bad[1]++;
    if (res_en_b) rq[1].push_back('{cyc, int'(res_addr_b), 32'd0});
    else if (res_addr_b != 0) bad[1]++;
    if (add_addr_b != res_addr_b) bad[1]++;
    if (done_b) dq[1].push_back(cyc);
  end

  always @(negedge clk) begin
    if (wr_c) wq[2].push_back('{cyc, int'(out_addr_c), out_data_c});
    else if (out_addr_c != 0 || out_data_c != 0) bad[2]++;
    if (res_en_c) rq[2].push_back('{cyc, int'(res_addr_c), 32'd0});
    else if (res_addr_c != 0) bad[2]++;
    if (add_addr_c != res_addr_c) bad[2]++;
    if (done_c) dq[2].push_back(cyc);
  end

  // vector-level model: byte j of the vector is r^a when j < vec, else 0
  function automatic logic [31:0] exp_word(input logic [31:0] r,
                                           input logic [31:0] a,
                                           input int k, input int ngf,
                                           input int vec);
    logic [31:0] y;
    y = '0;
    for (int i = 0; i < ngf; i++)
      if (k*ngf + i < vec) y[8*i +: 8] = r[8*i +: 8] ^ a[8*i +: 8];
    return y;
  endfunction

  // event logs since wb/rb/db, cycles renumbered so edge 0 starts cycle 1
  task automatic collect(input int i, input int e0, input int wb,
                         input int rb, input int db,
                         output evq_t w, output evq_t r, output intq_t d);
    w = {};
    r = {};
    d = {};
    for (int k = wb; k < wq[i].size(); k++) begin
      ev_t e;
      e = wq[i][k];
      e.c = e.c - e0 + 1;
      w.push_back(e);
    end
    for (int k = rb; k < rq[i].size(); k++) begin
      ev_t e;
      e = rq[i][k];
      e.c = e.c - e0 + 1;
      r.push_back(e);
    end
    for (int k = db; k < dq[i].size(); k++) d.push_back(dq[i][k] - e0 + 1);
  endtask

  task automatic run_once(input int i, output evq_t w, output evq_t r,
                          output intq_t d, output int nbad);
    int wb, rb, db, bb, e0;
    wb = wq[i].size();
    rb = rq[i].size();
    db = dq[i].size();
    bb = bad[i];
    @(negedge clk);
    start[i] = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    start[i] = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    collect(i, e0, wb, rb, db, w, r, d);
    nbad = bad[i] - bb;
  endtask

  task automatic test_reset();
    logic [63:0] sa, sb, sc;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    sa = {res_en_a, res_addr_a, add_addr_a, wr_a, out_addr_a, out_data_a,
          busy_a, done_a};
    sb = {res_en_b, res_addr_b, add_addr_b, wr_b, out_addr_b, out_data_b,
          busy_b, done_b};
    sc = {res_en_c, res_addr_c, add_addr_c, wr_c, out_addr_c, out_data_c,
          busy_c, done_c};
    ncmp++;
    if (sa !== 64'd0) begin
      nerr++;
      $display("FAIL reset_a: outputs %h, want 0", sa);
    end
    ncmp++;
    if (sb !== 64'd0) begin
      nerr++;
      $display("FAIL reset_b: outputs %h, want 0", sb);
    end
    ncmp++;
    if (sc !== 64'd0) begin
      nerr++;
      $display("FAIL reset_c: outputs %h, want 0", sc);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_passthrough();
    evq_t w, r;
    intq_t d;
    int nb;
    logic [31:0] tbl[4] = '{32'h1234, 32'hABCD, 32'h00FF, 32'h8001};
    for (int k = 0; k < 4; k++) begin
      rmem[0][k] = tbl[k];
      amem[0][k] = 32'h0;
    end
    run_once(0, w, r, d, nb);
    ncmp++;
    if (w.size() !== 4) begin
      nerr++;
      $display("FAIL pass_nwr: got %0d writes, want 4", w.size());
    end
    for (int k = 0; k < w.size() && k < 4; k++) begin
      ncmp++;
      if (w[k].c !== 3 + k || w[k].a !== k || w[k].d !== tbl[k]) begin
        nerr++;
        $display("FAIL pass_wr%0d: got c%0d a%0d %h, want c%0d a%0d %h",
                 k, w[k].c, w[k].a, w[k].d, 3 + k, k, tbl[k]);
      end
    end
    ncmp++;
    if (d.size() !== 1 || d[0] !== 7) begin
      nerr++;
      $display("FAIL pass_done: got %0d pulses first c%0d, want 1 at c7",
               d.size(), d.size() > 0 ? d[0] : -1);
    end
    ncmp++;
    if (nb !== 0) begin
      nerr++;
      $display("FAIL pass_idle: %0d nonzero idle outputs, want 0", nb);
    end
  endtask

  task automatic test_xor();
    evq_t w, r;
    intq_t d;
    int nb;
    logic [31:0] rt[4] = '{32'h1234, 32'hABCD, 32'h00FF, 32'h8001};
    logic [31:0] at[4] = '{32'h1234, 32'h0000, 32'hFF00, 32'h0001};
    logic [31:0] yt[4] = '{32'h0000, 32'hABCD, 32'hFFFF, 32'h8000};
    for (int k = 0; k < 4; k++) begin
      rmem[0][k] = rt[k];
      amem[0][k] = at[k];
    end
    run_once(0, w, r, d, nb);
    ncmp++;
    if (w.size() !== 4 || r.size() !== 4) begin
      nerr++;
      $display("FAIL xor_cnt: got %0d wr %0d rd, want 4 4", w.size(), r.size());
    end
    for (int k = 0; k < w.size() && k < r.size() && k < 4; k++) begin
      ncmp++;
      if (w[k].d !== yt[k] || w[k].a !== k || r[k].a !== k ||
          r[k].c !== 1 + k || w[k].c !== r[k].c + 2) begin
        nerr++;
        $display("FAIL xor_wr%0d: got rd c%0d a%0d wr c%0d a%0d %h, want rd c%0d wr +2 %h",
                 k, r[k].c, r[k].a, w[k].c, w[k].a, w[k].d, 1 + k, yt[k]);
      end
    end
  endtask

  task automatic test_tail_mask();
    evq_t w, r;
    intq_t d;
    int nb;
    logic [31:0] e;
    for (int k = 0; k < 3; k++) begin
      rmem[1][k] = $urandom & 32'hFFFF;
      amem[1][k] = $urandom & 32'hFFFF;
    end
    rmem[1][3] = 32'hFFAA;
    amem[1][3] = 32'h0F00;
    run_once(1, w, r, d, nb);
    ncmp++;
    if (w.size() !== 4) begin
      nerr++;
      $display("FAIL tail_nwr: got %0d writes, want 4", w.size());
    end
    for (int k = 0; k < w.size() && k < 4; k++) begin
      e = exp_word(rmem[1][k], amem[1][k], k, 2, 7);
      ncmp++;
      if (w[k].d !== e || w[k].a !== k || w[k].c !== 3 + k) begin
        nerr++;
        $display("FAIL tail_wr%0d: got c%0d a%0d %h, want c%0d a%0d %h",
                 k, w[k].c, w[k].a, w[k].d, 3 + k, k, e);
      end
    end
    ncmp++;
    if (w.size() < 4 || w[3].d !== 32'h00AA) begin
      nerr++;
      $display("FAIL tail_word3: got %h, want 000000aa",
               w.size() < 4 ? 32'hx : w[3].d);
    end
    ncmp++;
    if (d.size() !== 1 || d[0] !== 7 || nb !== 0) begin
      nerr++;
      $display("FAIL tail_done: got %0d pulses, %0d idle errs, want 1 at c7, 0",
               d.size(), nb);
    end
  endtask

  task automatic test_back_to_back();
    evq_t w, r;
    intq_t d;
    int wb, rb, db, e0;
    logic [31:0] e;
    for (int k = 0; k < 4; k++) begin
      rmem[0][k] = $urandom & 32'hFFFF;
      amem[0][k] = $urandom & 32'hFFFF;
    end
    wb = wq[0].size();
    rb = rq[0].size();
    db = dq[0].size();
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    start[0] = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start[0] = (c == 2 || c == 7 || c == 8);
      @(posedge clk);
      #1;
      start[0] = 1'b0;
    end
    collect(0, e0, wb, rb, db, w, r, d);
    ncmp++;
    if (w.size() !== 8) begin
      nerr++;
      $display("FAIL b2b_nwr: got %0d writes, want 8", w.size());
    end
    for (int k = 0; k < w.size() && k < 8; k++) begin
      e = exp_word(rmem[0][k%4], amem[0][k%4], k%4, 2, 8);
      ncmp++;
      if (w[k].d !== e || w[k].a !== k%4 ||
          w[k].c !== (k < 4 ? 3 + k : 11 + k - 4)) begin
        nerr++;
        $display("FAIL b2b_wr%0d: got c%0d a%0d %h, want c%0d a%0d %h",
                 k, w[k].c, w[k].a, w[k].d, k < 4 ? 3 + k : 7 + k, k%4, e);
      end
    end
    ncmp++;
    if (d.size() !== 2 || d[0] !== 7 || d[1] !== 15) begin
      nerr++;
      $display("FAIL b2b_done: got %0d pulses, want 2 at c7 c15", d.size());
    end
  endtask

  task automatic test_reset_mid();
    evq_t w, r;
    intq_t d;
    int wb, rb, db, e0, nb;
    logic [31:0] e;
    logic [31:0] s;
    for (int k = 0; k < 4; k++) begin
      rmem[0][k] = $urandom & 32'hFFFF;
      amem[0][k] = $urandom & 32'hFFFF;
    end
    wb = wq[0].size();
    rb = rq[0].size();
    db = dq[0].size();
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    start[0] = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    s = {res_en_a, res_addr_a, add_addr_a, wr_a, out_addr_a, out_data_a,
         busy_a, done_a};
    ncmp++;
    if (s !== 32'd0) begin
      nerr++;
      $display("FAIL rstmid_out: outputs %h, want 0", s);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    collect(0, e0, wb, rb, db, w, r, d);
    ncmp++;
    if (w.size() !== 1 || d.size() !== 0) begin
      nerr++;
      $display("FAIL rstmid_abort: got %0d writes %0d done, want 1 0",
               w.size(), d.size());
    end
    run_once(0, w, r, d, nb);
    ncmp++;
    if (w.size() !== 4 || d.size() !== 1 || d[0] !== 7) begin
      nerr++;
      $display("FAIL rstmid_rerun: got %0d writes %0d done, want 4 1",
               w.size(), d.size());
    end
    for (int k = 0; k < w.size() && k < 4; k++) begin
      e = exp_word(rmem[0][k], amem[0][k], k, 2, 8);
      ncmp++;
      if (w[k].d !== e || w[k].a !== k || w[k].c !== 3 + k) begin
        nerr++;
        $display("FAIL rstmid_wr%0d: got c%0d a%0d %h, want c%0d a%0d %h",
                 k, w[k].c, w[k].a, w[k].d, 3 + k, k, e);
      end
    end
  endtask

  task automatic test_single_word();
    evq_t w, r;
    intq_t d;
    int nb;
    rmem[2][0] = 32'hDEADBEEF;
    amem[2][0] = 32'hFFFFFFFF;
    run_once(2, w, r, d, nb);
    ncmp++;
    if (w.size() !== 1 || w[0].d !== 32'h21524110 || w[0].a !== 0 ||
        w[0].c !== 3) begin
      nerr++;
      $display("FAIL single_wr: got %0d writes first %h c%0d, want 1 21524110 at c3",
               w.size(), w.size() > 0 ? w[0].d : 32'hx,
               w.size() > 0 ? w[0].c : -1);
    end
    ncmp++;
    if (r.size() !== 1 || d.size() !== 1 || d[0] !== 4) begin
      nerr++;
      $display("FAIL single_done: got %0d reads %0d done, want 1 read done c4",
               r.size(), d.size());
    end
    ncmp++;
    if (nb !== 0) begin
      nerr++;
      $display("FAIL single_idle: %0d nonzero idle outputs, want 0", nb);
    end
  endtask

  task automatic test_random();
    evq_t w, r;
    intq_t d;
    int nb, i, vec;
    logic [31:0] e;
    for (int it = 0; it < 6; it++) begin
      i = it % 2;
      vec = (i == 0) ? 8 : 7;
      for (int k = 0; k < 4; k++) begin
        rmem[i][k] = $urandom & 32'hFFFF;
        amem[i][k] = $urandom & 32'hFFFF;
      end
      run_once(i, w, r, d, nb);
      ncmp++;
      if (w.size() !== 4 || d.size() !== 1 || d[0] !== 7 || nb !== 0) begin
        nerr++;
        $display("FAIL rand%0d_shape: %0d writes %0d done %0d idle errs, want 4 1 0",
                 it, w.size(), d.size(), nb);
      end
      for (int k = 0; k < w.size() && k < 4; k++) begin
        e = exp_word(rmem[i][k], amem[i][k], k, 2, vec);
        ncmp++;
        if (w[k].d !== e || w[k].a !== k || w[k].c !== 3 + k) begin
          nerr++;
          $display("FAIL rand%0d_wr%0d: got c%0d a%0d %h, want c%0d a%0d %h",
                   it, k, w[k].c, w[k].a, w[k].d, 3 + k, k, e);
        end
      end
    end
  endtask

  initial begin
    start = 3'b000;
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 4; k++) begin
        rmem[i][k] = 32'h0;
        amem[i][k] = 32'h0;
      end
    test_reset();
    test_passthrough();
    test_xor();
    test_tail_mask();
    test_back_to_back();
    test_reset_mid();
    test_single_word();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
